// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline control unit. It merges stage stall requests into a
//               6-bit stall vector. It also generates the flush pulse with its
//               redirect PC, and runs a stall watchdog.
//               Optional macro PIPE_CTRL_PERF_EN adds performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_STALL    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        flush_req,
    input  logic [31:0] flush_pc,
    output logic [5:0]  stall,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        stall_timeout_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [15:0] perf_flush_cnt
`endif
);

    localparam logic [1:0]  c_run         = 2'd0;
    localparam logic [1:0]  c_stall       = 2'd1;
    localparam logic [1:0]  c_flush       = 2'd2;
    localparam logic [3:0]  c_fcnt_init   = 4'(FLUSH_CYCLES - 1);
    localparam logic [15:0] c_stall_limit = 16'(MAX_STALL - 1);
    localparam logic [15:0] c_scnt_max    = 16'hFFFF;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_fcnt;
    logic [15:0] r_scnt;
    logic [31:0] r_new_pc;
    logic        r_timeout;
    logic [5:0]  w_stall;
    logic        w_any_req;

    assign w_any_req = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;

    // Stall vectors are contiguous runs from bit 0, so the first unstalled stage gets a bubble.
    always_comb begin
        w_stall = 6'b000000;
        if (r_state != c_flush) begin
            if (stallreq_mem)      w_stall = 6'b011111;
            else if (stallreq_ex)  w_stall = 6'b001111;
            else if (stallreq_id)  w_stall = 6'b000111;
            else if (stallreq_if)  w_stall = 6'b000011;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_run, c_stall: begin
                if (flush_req)      w_state_nxt = c_flush;
                else if (w_any_req) w_state_nxt = c_stall;
                else                w_state_nxt = c_run;
            end
            c_flush: begin
                if (flush_req)            w_state_nxt = c_flush;
                else if (r_fcnt == 4'd0)  w_state_nxt = c_run;
            end
            default: w_state_nxt = c_run;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_run;
            r_fcnt    <= 4'd0;
            r_scnt    <= 16'd0;
            r_new_pc  <= 32'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // A flush request always (re)starts the flush window, even mid-flush.
            if (flush_req) begin
                r_fcnt   <= c_fcnt_init;
                r_new_pc <= flush_pc;
            end else if ((r_state == c_flush) && (r_fcnt != 4'd0)) begin
                r_fcnt <= r_fcnt - 4'd1;
            end
            if (w_stall != 6'b000000) begin
                if (r_scnt != c_scnt_max) r_scnt <= r_scnt + 16'd1;
                if (r_scnt >= c_stall_limit) r_timeout <= 1'b1;
            end else begin
                r_scnt <= 16'd0;
            end
        end
    end

    assign stall           = w_stall;
    assign flush_o         = (r_state == c_flush);
    assign new_pc_o        = r_new_pc;
    assign stall_timeout_o = r_timeout;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall;
    logic [15:0] r_perf_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall <= 32'd0;
            r_perf_flush <= 16'd0;
        end else begin
            if (w_stall != 6'b000000) r_perf_stall <= r_perf_stall + 32'd1;
            if (flush_req)            r_perf_flush <= r_perf_flush + 16'd1;
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_flush_cnt    = r_perf_flush;
`endif

endmodule

`default_nettype wire
